// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I control unit
// Purpose: FSM state enum, opcode constants, ALU control enum, mux-select encodings
//          and the opcode -> immediate-format helper used by the control unit.
// Ports:   none (package)
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    JAL,
    BRANCH,
    ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Only word accesses are supported on the shared memory port.
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // R-type has no immediate and falls back to I like any undefined opcode.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational ALUOp/funct3 to ALUControl decode
// Purpose: maps the FSM's ALUOp plus instruction fields to the ALU operation and
//          flags funct3 values the ALU cannot execute.
// Ports:   alu_op[1:0], funct3[2:0], op_b5, funct7_b5 in; alu_control[2:0], alu_illegal out
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7_b5,
  output logic [2:0] alu_control,
  output logic       alu_illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    alu_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-type so ADDI with bit 30 set stays ADD.
          3'b000:  alu_control = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM on a shared memory port
// Purpose: sequences fetch/decode/execute over several clocks and drives every datapath
//          enable and mux select; traps unsupported instructions and counts retirements.
// Ports:   clk, rst_n, instruction[31:0], zero_flg, lt_flg, ltu_flg, mem_ready in;
//          mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc[1:0],
//          ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[1:0], ALUControl[2:0], illegal_o,
//          instret_o[CNT_W-1:0] out
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned FULL_BRANCH = 1,
  parameter int unsigned MEM_HANDSHK = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction,
  input  logic             zero_flg,
  input  logic             lt_flg,
  input  logic             ltu_flg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  state_t     state;
  state_t     next_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       rdy;
  logic [1:0] alu_op;
  logic [2:0] alu_control;
  logic       alu_illegal_unused;
  logic [2:0] chk_control_unused;
  logic       funct3_illegal;
  logic       branch_legal;
  logic       branch_taken;
  logic       retire;
  logic       unused_bits;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];
  assign unused_bits = &{instruction[31], instruction[29:15], instruction[11:7],
                         alu_illegal_unused, chk_control_unused};

  assign rdy = (MEM_HANDSHK != 0) ? mem_ready : 1'b1;

  // Drives ALUControl from the current state's ALUOp.
  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (opcode[5]),
    .funct7_b5   (funct7_b5),
    .alu_control (alu_control),
    .alu_illegal (alu_illegal_unused)
  );

  // Legality probe: DECODE must know whether R/I funct3 is executable while its own
  // ALUOp is ADD, so the funct3 decode is evaluated separately here.
  alu_decoder u_alu_chk (
    .alu_op      (ALUOP_FUNCT),
    .funct3      (funct3),
    .op_b5       (opcode[5]),
    .funct7_b5   (funct7_b5),
    .alu_control (chk_control_unused),
    .alu_illegal (funct3_illegal)
  );

  assign branch_legal = (funct3 == 3'b000) ||
                        ((FULL_BRANCH != 0) && (funct3 != 3'b010) && (funct3 != 3'b011));

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero_flg;
      3'b001:  branch_taken = ~zero_flg;
      3'b100:  branch_taken = lt_flg;
      3'b101:  branch_taken = ~lt_flg;
      3'b110:  branch_taken = ltu_flg;
      3'b111:  branch_taken = ~ltu_flg;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (rdy) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = (funct3 == F3_WORD) ? MEMADR : ILLEGAL;
          OP_RTYPE:          next_state = funct3_illegal ? ILLEGAL : EXECR;
          OP_ITYPE:          next_state = funct3_illegal ? ILLEGAL : EXECI;
          OP_JAL:            next_state = JAL;
          OP_BRANCH:         next_state = branch_legal ? BRANCH : ILLEGAL;
          default:           next_state = ILLEGAL;
        endcase
      end
      MEMADR:   next_state = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (rdy) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (rdy) next_state = FETCH;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      JAL:      next_state = ALUWB;
      BRANCH:   next_state = FETCH;
      default:  next_state = ILLEGAL;
    endcase
  end

  // JAL retires through ALUWB, so it is counted exactly once.
  assign retire = (next_state == FETCH) &&
                  ((state == MEMWB) || (state == MEMWRITE) ||
                   (state == ALUWB) || (state == BRANCH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      instret_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= next_state;
      if (retire) instret_o <= instret_o + CNT_W'(1);
      if (next_state == ILLEGAL) illegal_o <= 1'b1;
    end
  end

  // Moore decode of state; reset forces every enable and select low.
  always_comb begin
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = rdy;
        PCWrite   = rdy;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = branch_taken;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req   = 1'b0;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
    end
  end

  assign ImmSrc     = rst_n ? imm_src_of(opcode) : 2'b00;
  assign ALUControl = rst_n ? alu_control : 3'b000;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        zero_flg, lt_flg, ltu_flg, mem_ready;

  logic        mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_o;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret_o;

  logic        b_mem_req, b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_illegal;
  logic [1:0]  b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
  logic [2:0]  b_ALUControl;
  logic [31:0] b_instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(.FULL_BRANCH(1), .MEM_HANDSHK(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero_flg(zero_flg),
    .lt_flg(lt_flg), .ltu_flg(ltu_flg), .mem_ready(mem_ready), .mem_req(mem_req),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_o(illegal_o), .instret_o(instret_o)
  );

  multicycle_control_unit #(.FULL_BRANCH(0), .MEM_HANDSHK(1), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .zero_flg(zero_flg),
    .lt_flg(lt_flg), .ltu_flg(ltu_flg), .mem_ready(mem_ready), .mem_req(b_mem_req),
    .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
    .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl), .illegal_o(b_illegal), .instret_o(b_instret)
  );

  typedef struct {
    logic [17:0] ctl;
    logic [17:0] mask;
    logic [31:0] instret;
    logic        chk_b;
    logic [5:0]  b_exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [17:0] act;
  logic [5:0]  b_act;
  assign act   = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_o};
  assign b_act = {b_illegal, b_mem_req, b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite};

  function automatic logic [17:0] v(input logic mr, pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, sa, sb, imm,
                                    input logic [2:0] alu, input logic ill);
    return {mr, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  // Monitor: one scoreboard entry describes one clock of DUT output.
  exp_t e;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if ((act & e.mask) !== (e.ctl & e.mask)) begin
        bad++;
        $display("FAIL %s ctl actual=%b required=%b", e.name, act & e.mask, e.ctl & e.mask);
      end
      total++;
      if (instret_o !== e.instret) begin
        bad++;
        $display("FAIL %s instret actual=%0d required=%0d", e.name, instret_o, e.instret);
      end
      if (e.chk_b) begin
        total++;
        if (b_act !== e.b_exp) begin
          bad++;
          $display("FAIL %s beq_only actual=%b required=%b", e.name, b_act, e.b_exp);
        end
      end
    end
  end

  task automatic cyc(input logic [17:0] c, input logic [31:0] ir, input string nm,
                     input logic cb = 1'b0, input logic [5:0] be = 6'b0,
                     input logic [17:0] m = 18'h3FFFF);
    exp_t x;
    x.ctl = c; x.mask = m; x.instret = ir; x.chk_b = cb; x.b_exp = be; x.name = nm;
    sbq.push_back(x);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; instruction = 32'h002081B3;
    zero_flg = 1'b0; lt_flg = 1'b0; ltu_flg = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(18'h0, 0, "reset_hold", 1'b1, 6'b000000);
    rst_n = 1'b1;

    // add x3,x1,x2
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 0, "add_fetch", 1'b1, 6'b011100);
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 0, "add_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0), 0, "add_execr");
    cyc(v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 0, "add_aluwb", 1'b1, 6'b000010);

    // sub x3,x1,x2
    instruction = 32'h402081B3;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1, "sub_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 1, "sub_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0), 1, "sub_execr");
    cyc(v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1, "sub_aluwb");

    // addi with bit 30 set must stay ADD
    instruction = 32'h40008093;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 2, "addi_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 2, "addi_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), 2, "addi_execi");
    cyc(v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 2, "addi_aluwb");

    // lw with three wait cycles
    instruction = 32'h0000A183;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 3, "lw_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 3, "lw_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), 3, "lw_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(v(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 3, "lw_memread_wait");
    mem_ready = 1'b1;
    cyc(v(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 3, "lw_memread_done");
    cyc(v(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0), 3, "lw_memwb");

    // sw with two wait cycles
    instruction = 32'h0020A023;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0), 4, "sw_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0), 4, "sw_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0), 4, "sw_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc(v(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0), 4, "sw_memwrite_wait");
    mem_ready = 1'b1;
    cyc(v(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0), 4, "sw_memwrite_done");

    // bne, fetch stalled one cycle; not taken (zero=1)
    instruction = 32'h00209463; zero_flg = 1'b1; mem_ready = 1'b0;
    cyc(v(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b10,3'b000,0), 5, "bne_fetch_stall");
    mem_ready = 1'b1;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0), 5, "bne_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), 5, "bne_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0), 5, "bne_nt_branch");
    // bne taken (zero=0); beq-only instance is trapped
    zero_flg = 1'b0;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0), 6, "bne2_fetch", 1'b1, 6'b100000);
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), 6, "bne2_decode", 1'b1, 6'b100000);
    cyc(v(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0), 6, "bne_t_branch", 1'b1, 6'b100000);

    // bltu taken
    instruction = 32'h0020E463; ltu_flg = 1'b1;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0), 7, "bltu_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0), 7, "bltu_decode");
    cyc(v(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0), 7, "bltu_branch");

    // reset while MEMWRITE has mem_req high
    instruction = 32'h0020A023;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0), 8, "sw2_fetch");
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0), 8, "sw2_decode");
    cyc(v(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0), 8, "sw2_memadr");
    mem_ready = 1'b0;
    cyc(v(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0), 8, "sw2_memwrite");
    rst_n = 1'b0;
    cyc(18'h0, 8, "rst_in_memwrite", 1'b1, 6'b100000);
    cyc(18'h0, 0, "rst_applied", 1'b1, 6'b000000);
    rst_n = 1'b1; mem_ready = 1'b1;

    // undefined opcode traps and stays trapped
    instruction = 32'h0000007F;
    cyc(v(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 0, "post_rst_fetch", 1'b1, 6'b011100);
    cyc(v(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), 0, "illop_decode");
    cyc(18'h0, 0, "illop_enter", 1'b0, 6'b0, 18'h3FFFE);
    for (int i = 0; i < 2; i++)
      cyc(v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), 0, "illop_hold");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
